// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with return-address stack; optional relative branch under PC_REL_BRANCH_EN
module pc_sequencer #(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pc_enable,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                offset,
    output logic [ADDR_W-1:0]                pc_out,
    output logic [ADDR_W-1:0]                ret_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_CALL   = 3'b010;
    localparam logic [2:0] OP_RET    = 3'b011;
`ifdef PC_REL_BRANCH_EN
    localparam logic [2:0] OP_BRANCH = 3'b100;
`endif

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] top;
    logic              full;
    logic              empty;
    logic              push;

`ifndef PC_REL_BRANCH_EN
    logic unused_offset;
    assign unused_offset = ^offset;
`endif

    assign full  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign nxt   = pc_q + ADDR_W'(1);

    // Top entry lives at sp-1; only meaningful when the stack is not empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SP_W'(i) == sp_q - SP_W'(1)) top = stack_q[i];
        end
    end

    always_comb begin
        pc_d        = pc_q;
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        if (pc_enable) begin
            case (op)
                OP_JUMP: pc_d = target;
                OP_CALL: begin
                    pc_d = target;
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d        = nxt;
                        underflow_d = 1'b1;
                    end else begin
                        pc_d = top;
                        sp_d = sp_q - SP_W'(1);
                    end
                end
`ifdef PC_REL_BRANCH_EN
                OP_BRANCH: pc_d = pc_q + offset;
`endif
                default: pc_d = nxt;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (push && (SP_W'(i) == sp_q)) stack_d[i] = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_ADDR;
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign pc_out      = pc_q;
    assign sp          = sp_q;
    assign ret_addr    = empty ? '0 : top;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pc_enable;
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic [7:0] pc_out;
    logic [7:0] ret_addr;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, CALL = 3'd2, RET = 3'd3, BR = 3'd4;

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .reset(reset), .pc_enable(pc_enable), .op(op),
        .target(target), .offset(offset), .pc_out(pc_out), .ret_addr(ret_addr),
        .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // pc(8) sp(3) ret_addr(8) full empty ovf unf
    logic [22:0] obs;
    assign obs = {pc_out, sp, ret_addr, stack_full, stack_empty, overflow, underflow};

    task automatic drive(input logic rst, input logic en, input logic [2:0] o,
                         input logic [7:0] t, input logic [7:0] off);
        reset = rst; pc_enable = en; op = o; target = t; offset = off;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, INC, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 1'b1, CALL, 8'h55, 8'h00);
        checks++;
        if (obs !== {8'h00, 3'd0, 8'h00, 4'b0100}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, {8'h00, 3'd0, 8'h00, 4'b0100});
        end
    endtask

    task automatic test_inc();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, INC, 8'h00, 8'h00);
            checks++;
            if (obs !== {8'(i), 3'd0, 8'h00, 4'b0100}) begin
                failures++;
                $display("FAIL inc_%0d got=%h exp=%h", i, obs, {8'(i), 3'd0, 8'h00, 4'b0100});
            end
        end
    endtask

    task automatic test_call_ret();
        logic [2:0]  ops [4] = '{CALL, CALL, RET, RET};
        logic [7:0]  tgt [4] = '{8'h40, 8'h80, 8'h00, 8'h00};
        logic [22:0] exp [4] = '{{8'h40, 3'd1, 8'h11, 4'b0000},
                                 {8'h80, 3'd2, 8'h41, 4'b0000},
                                 {8'h41, 3'd1, 8'h11, 4'b0000},
                                 {8'h11, 3'd0, 8'h00, 4'b0100}};
        do_reset();
        drive(1'b0, 1'b1, JMP, 8'h10, 8'h00);
        checks++;
        if (pc_out !== 8'h10) begin
            failures++;
            $display("FAIL jump_10 got=%h exp=10", pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, ops[i], tgt[i], 8'h00);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL call_ret_%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [22:0] exp [9] = '{{8'h20, 3'd1, 8'h01, 4'b0000},
                                 {8'h20, 3'd2, 8'h21, 4'b0000},
                                 {8'h20, 3'd3, 8'h21, 4'b0000},
                                 {8'h20, 3'd4, 8'h21, 4'b1000},
                                 {8'h20, 3'd4, 8'h21, 4'b1010},
                                 {8'h21, 3'd3, 8'h21, 4'b0010},
                                 {8'h21, 3'd2, 8'h21, 4'b0010},
                                 {8'h21, 3'd1, 8'h01, 4'b0010},
                                 {8'h01, 3'd0, 8'h00, 4'b0110}};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, (i < 5) ? CALL : RET, 8'h20, 8'h00);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL overflow_%0d got=%h exp=%h", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(1'b0, 1'b1, JMP, 8'hFF, 8'h00);
        drive(1'b0, 1'b1, RET, 8'h00, 8'h00);
        checks++;
        if (obs !== {8'h00, 3'd0, 8'h00, 4'b0101}) begin
            failures++;
            $display("FAIL underflow_ret got=%h exp=%h", obs, {8'h00, 3'd0, 8'h00, 4'b0101});
        end
        drive(1'b0, 1'b1, INC, 8'h00, 8'h00);
        checks++;
        if (obs !== {8'h01, 3'd0, 8'h00, 4'b0101}) begin
            failures++;
            $display("FAIL underflow_sticky got=%h exp=%h", obs, {8'h01, 3'd0, 8'h00, 4'b0101});
        end
        do_reset();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear got=%b exp=0", underflow);
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_pc;
`ifdef PC_REL_BRANCH_EN
        exp_pc = 8'h02;
`else
        exp_pc = 8'h06;
`endif
        do_reset();
        drive(1'b0, 1'b1, JMP, 8'h05, 8'h00);
        drive(1'b0, 1'b1, BR, 8'h99, 8'hFD);
        checks++;
        if (obs !== {exp_pc, 3'd0, 8'h00, 4'b0100}) begin
            failures++;
            $display("FAIL branch got=%h exp=%h", obs, {exp_pc, 3'd0, 8'h00, 4'b0100});
        end
    endtask

    task automatic test_reserved();
        do_reset();
        drive(1'b0, 1'b1, CALL, 8'h30, 8'h00);
        for (int i = 5; i <= 7; i++) begin
            drive(1'b0, 1'b1, 3'(i), 8'hAA, 8'h10);
            checks++;
            if (obs !== {8'h30 + 8'(i - 4), 3'd1, 8'h01, 4'b0000}) begin
                failures++;
                $display("FAIL reserved_op%0d got=%h exp=%h", i, obs,
                         {8'h30 + 8'(i - 4), 3'd1, 8'h01, 4'b0000});
            end
        end
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        drive(1'b0, 1'b1, CALL, 8'h30, 8'h00);
        drive(1'b0, 1'b1, CALL, 8'h50, 8'h00);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'(i), 8'hC3, 8'h7F);
            checks++;
            if (obs !== {8'h50, 3'd2, 8'h31, 4'b0000}) begin
                failures++;
                $display("FAIL hold_op%0d got=%h exp=%h", i, obs, {8'h50, 3'd2, 8'h31, 4'b0000});
            end
        end
        drive(1'b1, 1'b1, CALL, 8'h77, 8'h00);
        checks++;
        if (obs !== {8'h00, 3'd0, 8'h00, 4'b0100}) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", obs, {8'h00, 3'd0, 8'h00, 4'b0100});
        end
        drive(1'b0, 1'b1, RET, 8'h00, 8'h00);
        checks++;
        if (obs !== {8'h01, 3'd0, 8'h00, 4'b0101}) begin
            failures++;
            $display("FAIL reset_no_stale got=%h exp=%h", obs, {8'h01, 3'd0, 8'h00, 4'b0101});
        end
    endtask

    initial begin
        reset = 1'b1; pc_enable = 1'b0; op = INC; target = 8'h00; offset = 8'h00;
        test_reset();
        test_inc();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_branch();
        test_reserved();
        test_hold_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
